ecc_78_wr_encoder: RTL and testbench
====================================

// Module: ecc_78_wr_encoder
// PURPOSE
//  Write-side SECDED encoder for the 78-bit FIFO ECC path; the transmit end of the 78/8 check code.
//  Accepts data on a valid/ready stream and emits the data word plus 8 check bits.
//  Output is registered behind a skid buffer so the FIFO write port sees full throughput and a registered s_ready.
//  A one-shot error-injection port corrupts one or two codeword bits, so the read-side checker can be exercised in system.
// PARAMETERS
//  DATA_WIDTH    78  data bits per word; fixed by the H-matrix below
//  PARITY_WIDTH  8   check bits per word
//  CNT_WIDTH     16  width of the encoded-word counter
// PORTS
//  clk          in   1    clock; all logic is rising-edge
//  rst_n        in   1    synchronous active-low reset
//  s_valid      in   1    input word valid
//  s_ready      out  1    input accept; registered
//  s_data       in   78   input data
//  m_valid      out  1    codeword valid
//  m_ready      in   1    downstream accept
//  m_data       out  78   data part of the codeword, after any injection
//  m_parity     out  8    check bits, after any injection
//  inj_arm      in   1    1-cycle pulse; captures inj_dbit, inj_pos0 and inj_pos1
//  inj_dbit     in   1    0: flip bit inj_pos0 only; 1: flip inj_pos0 and inj_pos1
//  inj_pos0     in   7    codeword bit index: 0..77 selects data, 78..85 selects parity[idx-78]
//  inj_pos1     in   7    second index; ignored when inj_dbit=0
//  inj_pending  out  1    an injection is armed and has not yet been applied
//  enc_cnt      out  16   words accepted on s_*; wraps modulo 2^CNT_WIDTH
// BEHAVIOUR
//  Reset (rst_n=0 at clk edge) gives:
//   - s_ready=1, m_valid=0, m_data=0, m_parity=0, inj_pending=0, enc_cnt=0
//   - skid buffer empty; any in-flight or armed state is discarded.
//  H-matrix:
//   - Data bit i takes code c(i), the (i+1)-th integer >=3 that is not a power of two: d0=3, d1=5, d2=6, d3=7, d4=9, ..., d77=85.
//   - For k=0..6: p[k] = XOR of d[i] over all i with c(i) bit k set.
//   - p[7] = XOR of d[i] over all i with popcount(c(i)) even, so every column has odd weight.
//  Handshake:
//   - Input transfer when s_valid & s_ready; output transfer when m_valid & m_ready.
//   - Latency is 1 cycle: a word accepted at edge N appears on m_* after edge N.
//   - Output register holds stable while m_valid & ~m_ready.
//   - If the output is stalled when a word is accepted, the word goes to the 1-entry skid register and s_ready drops on the next cycle.
//   - The skid register drains to the output on the first m_ready; s_ready returns to 1 the cycle after.
//   - Sustains 1 word/cycle with m_ready held at 1. Word order is preserved; no drop, no duplicate.
//  Injection:
//   - inj_arm latches the fields and sets inj_pending.
//   - The XOR mask is applied to the next word accepted at an edge strictly after the arm edge; inj_pending clears on that edge.
//   - inj_arm while pending overwrites the latched fields.
//   - inj_pos >= 86 flips nothing. inj_dbit=1 with pos0==pos1 flips nothing.
//  Counting: enc_cnt increments on every input transfer, whether or not the word is injected.
//  Simultaneous events: in the same edge the output drains and the skid loads or the input passes through; handle without a bubble.
// TESTING
//  s_data=0 -> m_data=0, m_parity=8'h00, one cycle after accept
//  s_data=1<<0 -> m_parity=8'h83; 1<<3 -> 8'h07; 1<<77 -> 8'hD5; all-ones 78-bit -> parity equal to the XOR of all 78 columns
//  Stream 1000 random words with random m_ready (50%) -> words arrive in order and unchanged, parity matches the reference model, enc_cnt=1000
//  Hold m_ready=0 with s_valid=1 -> exactly 2 words accepted, s_ready=0 from the third cycle; release -> both drain in order
//  Arm inj_pos0=5, inj_dbit=0, send data 0 -> m_data=78'h20, m_parity=0, inj_pending 1->0; next word is not corrupted
//  Arm inj_dbit=1, pos 0 and 80, send 0 -> m_data=1, m_parity=8'h04; reset mid-stall -> m_valid=0, s_ready=1, enc_cnt=0

Source files
------------

// File: rtl/ecc_78_wr_encoder_if.sv
// Valid/ready stream bundle for the 78/8 SECDED write encoder: data in on s_*, codeword out on m_*.
interface ecc_78_wr_encoder_if #(
   parameter int DATA_WIDTH   = 78,
   parameter int PARITY_WIDTH = 8
);
   logic                    s_valid;
   logic                    s_ready;
   logic [DATA_WIDTH-1:0]   s_data;
   logic                    m_valid;
   logic                    m_ready;
   logic [DATA_WIDTH-1:0]   m_data;
   logic [PARITY_WIDTH-1:0] m_parity;

   modport slave (
      input  s_valid, s_data, m_ready,
      output s_ready, m_valid, m_data, m_parity
   );

   modport master (
      output s_valid, s_data, m_ready,
      input  s_ready, m_valid, m_data, m_parity
   );
endinterface

// File: rtl/ecc_78_wr_encoder.sv
// Write-side SECDED encoder: 78 data bits -> 8 check bits, skid-buffered output,
// one-shot single/double bit error injection and an accepted-word counter.
module ecc_78_wr_encoder #(
   parameter int DATA_WIDTH   = 78,
   parameter int PARITY_WIDTH = 8,
   parameter int CNT_WIDTH    = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   ecc_78_wr_encoder_if.slave    bus,
   input  logic                  inj_arm,
   input  logic                  inj_dbit,
   input  logic [6:0]            inj_pos0,
   input  logic [6:0]            inj_pos1,
   output logic                  inj_pending,
   output logic [CNT_WIDTH-1:0]  enc_cnt
);

   localparam int CW_WIDTH  = DATA_WIDTH + PARITY_WIDTH;
   localparam int CODE_BITS = PARITY_WIDTH - 1;

   // Column codes: successive integers >= 3 that are not powers of two.
   function automatic logic [DATA_WIDTH-1:0][CODE_BITS-1:0] gen_codes();
      logic [DATA_WIDTH-1:0][CODE_BITS-1:0] codes;
      int n;
      codes = '0;
      n     = 0;
      for (int v = 3; v < (1 << CODE_BITS); v++) begin
         if (((v & (v - 1)) != 0) && (n < DATA_WIDTH)) begin
            codes[n] = CODE_BITS'(v);
            n++;
         end
      end
      return codes;
   endfunction

   localparam logic [DATA_WIDTH-1:0][CODE_BITS-1:0] CODES = gen_codes();

   logic [PARITY_WIDTH-1:0] parity;
   logic [CW_WIDTH-1:0]     inj_mask;
   logic [CW_WIDTH-1:0]     in_cw;

   logic                    inj_pending_q;
   logic                    inj_dbit_q;
   logic [6:0]              inj_pos0_q;
   logic [6:0]              inj_pos1_q;

   logic                    out_valid;
   logic [CW_WIDTH-1:0]     out_cw;
   logic                    skid_valid;
   logic [CW_WIDTH-1:0]     skid_cw;
   logic [CNT_WIDTH-1:0]    cnt_q;

   logic                    in_xfer;
   logic                    out_free;

   always_comb begin
      parity = '0;
      for (int i = 0; i < DATA_WIDTH; i++) begin
         for (int k = 0; k < CODE_BITS; k++) begin
            parity[k] = parity[k] ^ (CODES[i][k] & bus.s_data[i]);
         end
         parity[PARITY_WIDTH-1] = parity[PARITY_WIDTH-1] ^ (~(^CODES[i]) & bus.s_data[i]);
      end
   end

   // Out-of-range positions match no bit; equal positions cancel in the XOR.
   always_comb begin
      inj_mask = '0;
      for (int b = 0; b < CW_WIDTH; b++) begin
         inj_mask[b] = (inj_pos0_q == 7'(b)) ^ (inj_dbit_q & (inj_pos1_q == 7'(b)));
      end
   end

   assign in_cw    = {parity, bus.s_data} ^ (inj_pending_q ? inj_mask : '0);
   assign in_xfer  = bus.s_valid & ~skid_valid;
   assign out_free = ~out_valid | bus.m_ready;

   // The skid entry is only ever loaded while s_ready is high, so it is empty whenever a new word arrives.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid     <= 1'b0;
         out_cw        <= '0;
         skid_valid    <= 1'b0;
         skid_cw       <= '0;
         inj_pending_q <= 1'b0;
         inj_dbit_q    <= 1'b0;
         inj_pos0_q    <= '0;
         inj_pos1_q    <= '0;
         cnt_q         <= '0;
      end else begin
         if (out_free) begin
            if (skid_valid) begin
               out_valid  <= 1'b1;
               out_cw     <= skid_cw;
               skid_valid <= 1'b0;
            end else if (in_xfer) begin
               out_valid  <= 1'b1;
               out_cw     <= in_cw;
            end else begin
               out_valid  <= 1'b0;
            end
         end else if (in_xfer) begin
            skid_valid <= 1'b1;
            skid_cw    <= in_cw;
         end

         if (in_xfer) begin
            cnt_q <= cnt_q + 1'b1;
         end

         if (in_xfer && inj_pending_q) begin
            inj_pending_q <= 1'b0;
         end
         if (inj_arm) begin
            inj_pending_q <= 1'b1;
            inj_dbit_q    <= inj_dbit;
            inj_pos0_q    <= inj_pos0;
            inj_pos1_q    <= inj_pos1;
         end
      end
   end

   assign bus.s_ready  = ~skid_valid;
   assign bus.m_valid  = out_valid;
   assign bus.m_data   = out_cw[DATA_WIDTH-1:0];
   assign bus.m_parity = out_cw[CW_WIDTH-1:DATA_WIDTH];
   assign inj_pending  = inj_pending_q;
   assign enc_cnt      = cnt_q;

endmodule

// File: tb/tb_ecc_78_wr_encoder.sv
// Scoreboard bench for ecc_78_wr_encoder: expected codewords are queued on accept
// and compared when the DUT hands them off downstream.
module tb_ecc_78_wr_encoder;

   logic        clk;
   logic        rst_n;
   logic        inj_arm;
   logic        inj_dbit;
   logic [6:0]  inj_pos0;
   logic [6:0]  inj_pos1;
   logic        inj_pending;
   logic [15:0] enc_cnt;
   logic        rand_ready;

   int total;
   int bad;
   logic [85:0] exp_q[$];

   ecc_78_wr_encoder_if #(.DATA_WIDTH(78), .PARITY_WIDTH(8)) bus ();

   ecc_78_wr_encoder #(
      .DATA_WIDTH   (78),
      .PARITY_WIDTH (8),
      .CNT_WIDTH    (16)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .bus         (bus),
      .inj_arm     (inj_arm),
      .inj_dbit    (inj_dbit),
      .inj_pos0    (inj_pos0),
      .inj_pos1    (inj_pos1),
      .inj_pending (inj_pending),
      .enc_cnt     (enc_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [85:0] got, input logic [85:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Reference check bits built straight from the column definition.
   function automatic logic [7:0] refParity(input logic [77:0] d);
      logic [7:0] p;
      int col;
      p   = '0;
      col = 0;
      for (int v = 3; v < 128; v++) begin
         if ($countones(v) != 1 && col < 78) begin
            if (d[col]) begin
               p[6:0] = p[6:0] ^ v[6:0];
               if (($countones(v) % 2) == 0) p[7] = ~p[7];
            end
            col++;
         end
      end
      return p;
   endfunction

   initial begin
      forever begin
         @(negedge clk);
         if (rst_n && bus.m_valid && bus.m_ready) begin
            if (exp_q.size() == 0) begin
               checkOutput("unexpected_word", {bus.m_parity, bus.m_data}, 86'h0);
               if ({bus.m_parity, bus.m_data} == 86'h0) begin
                  bad++;
                  $display("[TB] FAIL unexpected_word got=valid exp=none");
               end
            end else begin
               checkOutput("codeword", {bus.m_parity, bus.m_data}, exp_q.pop_front());
            end
         end
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rand_ready) bus.m_ready = 1'($urandom_range(0, 1));
      end
   end

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   // Holds the word on s_* until it is taken; xor_mask is the corruption the injection should cause.
   task automatic applyStimulus(input logic [77:0] d, input logic [85:0] xor_mask);
      logic taken;
      bus.s_valid = 1'b1;
      bus.s_data  = d;
      taken = 1'b0;
      for (int c = 0; c < 300 && !taken; c++) begin
         @(negedge clk);
         taken = bus.s_ready;
         if (taken) exp_q.push_back({refParity(d), d} ^ xor_mask);
         nextCycle();
      end
      if (!taken) begin
         bad++;
         $display("[TB] FAIL accept_timeout got=stuck exp=accepted");
      end
   endtask

   task automatic idle();
      bus.s_valid = 1'b0;
   endtask

   task automatic waitDrain();
      for (int c = 0; c < 200 && exp_q.size() != 0; c++) nextCycle();
      checkOutput("drain_empty", 86'(exp_q.size()), 86'd0);
   endtask

   task automatic arm(input logic dbit, input logic [6:0] p0, input logic [6:0] p1);
      inj_arm  = 1'b1;
      inj_dbit = dbit;
      inj_pos0 = p0;
      inj_pos1 = p1;
      nextCycle();
      inj_arm  = 1'b0;
   endtask

   task automatic doReset();
      rst_n = 1'b0;
      nextCycle();
      nextCycle();
      rst_n = 1'b1;
      exp_q.delete();
   endtask

   logic [77:0] ones;
   logic [7:0]  all_cols;
   int          accepted;

   initial begin
      total      = 0;
      bad        = 0;
      rand_ready = 1'b0;
      rst_n      = 1'b0;
      inj_arm    = 1'b0;
      inj_dbit   = 1'b0;
      inj_pos0   = '0;
      inj_pos1   = '0;
      bus.s_valid = 1'b0;
      bus.s_data  = '0;
      bus.m_ready = 1'b1;
      doReset();

      checkOutput("rst_s_ready", 86'(bus.s_ready), 86'd1);
      checkOutput("rst_m_valid", 86'(bus.m_valid), 86'd0);
      checkOutput("rst_m_cw", {bus.m_parity, bus.m_data}, 86'd0);
      checkOutput("rst_pending", 86'(inj_pending), 86'd0);
      checkOutput("rst_cnt", 86'(enc_cnt), 86'd0);

      // Hand-derived parity vectors plus the reference model on all-ones.
      checkOutput("ref_d0", 86'(refParity(78'h1)), 86'h83);
      checkOutput("ref_d3", 86'(refParity(78'h8)), 86'h07);
      checkOutput("ref_d77", 86'(refParity(78'h1 << 77)), 86'hD5);
      ones = '1;
      all_cols = 8'h00;
      for (int i = 0; i < 78; i++) all_cols = all_cols ^ refParity(78'h1 << i);
      applyStimulus(78'h0, '0);
      applyStimulus(78'h1, '0);
      applyStimulus(78'h8, '0);
      applyStimulus(78'h1 << 77, '0);
      applyStimulus(ones, '0);
      exp_q[exp_q.size()-1] = {all_cols, ones};
      idle();
      waitDrain();

      arm(1'b0, 7'd5, 7'd0);
      checkOutput("pending_set", 86'(inj_pending), 86'd1);
      applyStimulus(78'h0, {8'h00, 78'h20});
      idle();
      checkOutput("pending_clr", 86'(inj_pending), 86'd0);
      applyStimulus(78'h0, '0);
      idle();
      waitDrain();

      arm(1'b1, 7'd0, 7'd80);
      applyStimulus(78'h0, {8'h04, 78'h1});
      idle();
      arm(1'b0, 7'd90, 7'd0);
      applyStimulus(78'h123, '0);
      idle();
      arm(1'b1, 7'd40, 7'd40);
      applyStimulus(78'h456, '0);
      idle();
      arm(1'b0, 7'd1, 7'd0);
      arm(1'b0, 7'd85, 7'd0);
      applyStimulus(78'h0, {8'h80, 78'h0});
      idle();
      waitDrain();

      // Stall: two words fit (output + skid), then s_ready must stay low.
      bus.m_ready = 1'b0;
      accepted = 0;
      bus.s_valid = 1'b1;
      for (int c = 0; c < 6; c++) begin
         bus.s_data = 78'(c + 100);
         @(negedge clk);
         if (bus.s_ready) begin
            accepted++;
            exp_q.push_back({refParity(78'(c + 100)), 78'(c + 100)});
         end
         if (c == 2) checkOutput("stall_s_ready", 86'(bus.s_ready), 86'd0);
         nextCycle();
      end
      idle();
      checkOutput("stall_accepted", 86'(accepted), 86'd2);
      bus.m_ready = 1'b1;
      waitDrain();

      bus.m_ready = 1'b0;
      applyStimulus(78'hAAA, '0);
      applyStimulus(78'hBBB, '0);
      idle();
      rst_n = 1'b0;
      nextCycle();
      rst_n = 1'b1;
      exp_q.delete();
      checkOutput("midrst_m_valid", 86'(bus.m_valid), 86'd0);
      checkOutput("midrst_s_ready", 86'(bus.s_ready), 86'd1);
      checkOutput("midrst_cnt", 86'(enc_cnt), 86'd0);
      bus.m_ready = 1'b1;

      rand_ready = 1'b1;
      for (int n = 0; n < 1000; n++) begin
         applyStimulus({14'($urandom), 32'($urandom), 32'($urandom)}, '0);
         if ($urandom_range(0, 3) == 0) begin
            idle();
            nextCycle();
         end
      end
      idle();
      waitDrain();
      rand_ready = 1'b0;
      bus.m_ready = 1'b1;
      checkOutput("stream_cnt", 86'(enc_cnt), 86'd1000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
